// File: rtl/execute_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_md
// Purpose  : Execute stage with a valid/ready handshake toward decode, a
//            single-cycle base ALU and an iterative radix-2 mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================

package rv32i_pkg;
    typedef enum logic [4:0] {
        INSTR_ADD, INSTR_SUB, INSTR_AND, INSTR_OR, INSTR_XOR, INSTR_SLL,
        INSTR_SRL, INSTR_SRA, INSTR_SLT, INSTR_SLTU, INSTR_ADDI, INSTR_LOAD,
        INSTR_STORE, INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR, INSTR_BEQ,
        INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU
    } rv32i_instr_e;
endpackage

// Single-cycle base-ISA ALU; result doubles as the load/store address.
module alu import rv32i_pkg::*; #(
    parameter int XLEN = 32
) (
    input  rv32i_instr_e     instr_type,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  result,
    output logic             take_branch,
    output logic [XLEN-1:0]  branch_target
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] rs1_imm;

    assign shamt   = rs2_data[SHW-1:0];
    assign rs1_imm = rs1_data + imm;

    // Decode the base op into result, branch decision and redirect target.
    always_comb begin
        result        = '0;
        take_branch   = 1'b0;
        branch_target = pc + imm;
        case (instr_type)
            INSTR_ADD:   result = rs1_data + rs2_data;
            INSTR_SUB:   result = rs1_data - rs2_data;
            INSTR_AND:   result = rs1_data & rs2_data;
            INSTR_OR:    result = rs1_data | rs2_data;
            INSTR_XOR:   result = rs1_data ^ rs2_data;
            INSTR_SLL:   result = rs1_data << shamt;
            INSTR_SRL:   result = rs1_data >> shamt;
            INSTR_SRA:   result = XLEN'($signed(rs1_data) >>> shamt);
            INSTR_SLT:   result = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(rs2_data)};
            INSTR_SLTU:  result = {{(XLEN-1){1'b0}}, rs1_data < rs2_data};
            INSTR_ADDI,
            INSTR_LOAD,
            INSTR_STORE: result = rs1_imm;
            INSTR_LUI:   result = imm;
            INSTR_AUIPC: result = pc + imm;
            INSTR_JAL: begin
                result      = pc + XLEN'(4);
                take_branch = 1'b1;
            end
            INSTR_JALR: begin
                result        = pc + XLEN'(4);
                take_branch   = 1'b1;
                branch_target = {rs1_imm[XLEN-1:1], 1'b0};
            end
            INSTR_BEQ:   take_branch = (rs1_data == rs2_data);
            INSTR_BNE:   take_branch = (rs1_data != rs2_data);
            INSTR_BLT:   take_branch = ($signed(rs1_data) < $signed(rs2_data));
            INSTR_BGE:   take_branch = ($signed(rs1_data) >= $signed(rs2_data));
            INSTR_BLTU:  take_branch = (rs1_data < rs2_data);
            INSTR_BGEU:  take_branch = (rs1_data >= rs2_data);
            default: ;
        endcase
    end
endmodule

module execute_stage_md import rv32i_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_ex_valid,
    output logic             ex_id_ready,
    input  rv32i_instr_e     id_ex_instr_type,
    input  logic             id_ex_md_en,
    input  logic [2:0]       id_ex_md_op,
    input  logic [XLEN-1:0]  id_ex_rs1_data,
    input  logic [XLEN-1:0]  id_ex_rs2_data,
    input  logic [XLEN-1:0]  id_ex_imm,
    input  logic [XLEN-1:0]  id_ex_pc,
    input  logic [4:0]       id_ex_rd_addr,
    input  logic             id_ex_write_en,
    output logic             ex_if_take_branch,
    output logic [XLEN-1:0]  ex_if_branch_target,
    output logic             ex_wb_valid,
    output logic [XLEN-1:0]  ex_wb_result,
    output logic             ex_wb_write_en,
    output logic [4:0]       ex_wb_rd_addr,
    output logic [XLEN-1:0]  mem_addr,
    output logic             ex_busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;       // product, or {remainder, quotient}
    logic [XLEN-1:0]   operand;   // multiplicand or divisor magnitude
    logic [2:0]        md_op;
    logic [4:0]        md_rd;
    logic              md_we;
    logic              neg_hi;    // product / quotient needs negation
    logic              neg_lo;    // remainder needs negation

    logic [XLEN-1:0] alu_result, alu_target;
    logic            alu_take;

    alu #(.XLEN(XLEN)) u_alu (
        .instr_type    (id_ex_instr_type),
        .rs1_data      (id_ex_rs1_data),
        .rs2_data      (id_ex_rs2_data),
        .imm           (id_ex_imm),
        .pc            (id_ex_pc),
        .result        (alu_result),
        .take_branch   (alu_take),
        .branch_target (alu_target)
    );

    assign mem_addr    = alu_result;
    assign ex_busy     = (state != S_IDLE);
    assign ex_id_ready = (state == S_IDLE) && !stall && !flush && !rst;

    logic accept, md_accept, base_accept;
    assign accept      = id_ex_valid && ex_id_ready;
    assign md_accept   = accept && id_ex_md_en;
    assign base_accept = accept && !id_ex_md_en;

    // Operand signedness: MUL/MULH/MULHSU/DIV/REM treat rs1 as signed,
    // MUL/MULH/DIV/REM treat rs2 as signed.
    logic            a_signed, b_signed, a_neg, b_neg, rs2_zero;
    logic [XLEN-1:0] a_mag, b_mag;
    assign a_signed = id_ex_md_op[2] ? !id_ex_md_op[0] : (id_ex_md_op != 3'd3);
    assign b_signed = id_ex_md_op[2] ? !id_ex_md_op[0] : !id_ex_md_op[1];
    assign a_neg    = a_signed && id_ex_rs1_data[XLEN-1];
    assign b_neg    = b_signed && id_ex_rs2_data[XLEN-1];
    assign a_mag    = a_neg ? -id_ex_rs1_data : id_ex_rs1_data;
    assign b_mag    = b_neg ? -id_ex_rs2_data : id_ex_rs2_data;
    assign rs2_zero = (id_ex_rs2_data == '0);

    // One radix-2 iteration: shift-add multiply / restoring divide.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [2*XLEN:0]   div_shift;
    logic [XLEN:0]     div_top, div_diff;
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = {acc, 1'b0};
    assign div_top   = div_shift[2*XLEN:XLEN];
    assign div_diff  = div_top - {1'b0, operand};
    assign div_next  = (div_top >= {1'b0, operand})
                     ? {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1}
                     : {div_top[XLEN-1:0], div_shift[XLEN-1:0]};

    // Sign correction and result selection once iteration completes.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   md_result;
    assign prod_fix = neg_hi ? -acc : acc;
    always_comb begin
        md_result = '0;
        case (md_op)
            3'd0:          md_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          md_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:    md_result = neg_hi ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:       md_result = neg_lo ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        endcase
    end

    // Mul/div sequencer: latch operands on accept, iterate XLEN times, then wait to retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            md_op   <= 3'd0;
            md_rd   <= 5'd0;
            md_we   <= 1'b0;
            neg_hi  <= 1'b0;
            neg_lo  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (md_accept) begin
                    state   <= S_BUSY;
                    cnt     <= '0;
                    acc     <= {{XLEN{1'b0}}, a_mag};
                    operand <= b_mag;
                    md_op   <= id_ex_md_op;
                    md_rd   <= id_ex_rd_addr;
                    md_we   <= id_ex_write_en;
                    // Divide by zero keeps the all-ones quotient unsigned.
                    neg_hi  <= (a_neg ^ b_neg) && !(id_ex_md_op[2] && rs2_zero);
                    neg_lo  <= a_neg;
                end
                S_BUSY: begin
                    acc <= md_op[2] ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1)) state <= S_DONE;
                end
                S_DONE: if (!stall) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output registers: flush clears, stall holds, otherwise load a retiring op or clear pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_if_take_branch   <= 1'b0;
            ex_if_branch_target <= '0;
            ex_wb_valid         <= 1'b0;
            ex_wb_result        <= '0;
            ex_wb_write_en      <= 1'b0;
            ex_wb_rd_addr       <= 5'd0;
        end else if (flush) begin
            ex_if_take_branch <= 1'b0;
            ex_wb_valid       <= 1'b0;
            ex_wb_write_en    <= 1'b0;
        end else if (!stall) begin
            if (state == S_DONE) begin
                ex_if_take_branch <= 1'b0;
                ex_wb_valid       <= 1'b1;
                ex_wb_result      <= md_result;
                ex_wb_write_en    <= md_we;
                ex_wb_rd_addr     <= md_rd;
            end else if (base_accept) begin
                ex_if_take_branch   <= alu_take;
                ex_if_branch_target <= alu_target;
                ex_wb_valid         <= 1'b1;
                ex_wb_result        <= alu_result;
                ex_wb_write_en      <= id_ex_write_en;
                ex_wb_rd_addr       <= id_ex_rd_addr;
            end else begin
                ex_if_take_branch <= 1'b0;
                ex_wb_valid       <= 1'b0;
                ex_wb_write_en    <= 1'b0;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_execute_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage_md
// Purpose  : Directed self-checking bench for execute_stage_md (XLEN = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage_md;
    import rv32i_pkg::*;

    logic         clk = 1'b0;
    logic         rst, stall, flush, id_ex_valid, id_ex_md_en, id_ex_write_en;
    logic         ex_id_ready, ex_if_take_branch, ex_wb_valid, ex_wb_write_en, ex_busy;
    rv32i_instr_e id_ex_instr_type;
    logic [2:0]   id_ex_md_op;
    logic [31:0]  id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc;
    logic [4:0]   id_ex_rd_addr, ex_wb_rd_addr;
    logic [31:0]  ex_if_branch_target, ex_wb_result, mem_addr;

    int total = 0;
    int bad   = 0;
    int cycles;
    int seen;

    execute_stage_md #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_ex_valid(id_ex_valid), .ex_id_ready(ex_id_ready),
        .id_ex_instr_type(id_ex_instr_type), .id_ex_md_en(id_ex_md_en),
        .id_ex_md_op(id_ex_md_op), .id_ex_rs1_data(id_ex_rs1_data),
        .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc),
        .id_ex_rd_addr(id_ex_rd_addr), .id_ex_write_en(id_ex_write_en),
        .ex_if_take_branch(ex_if_take_branch), .ex_if_branch_target(ex_if_branch_target),
        .ex_wb_valid(ex_wb_valid), .ex_wb_result(ex_wb_result),
        .ex_wb_write_en(ex_wb_write_en), .ex_wb_rd_addr(ex_wb_rd_addr),
        .mem_addr(mem_addr), .ex_busy(ex_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        id_ex_valid = 1'b0;
        id_ex_md_en = 1'b0;
    endtask

    task automatic drive_base(input rv32i_instr_e t, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [4:0] rd, input logic we);
        id_ex_valid      = 1'b1;
        id_ex_md_en      = 1'b0;
        id_ex_instr_type = t;
        id_ex_rs1_data   = a;
        id_ex_rs2_data   = b;
        id_ex_imm        = imm;
        id_ex_pc         = pc;
        id_ex_rd_addr    = rd;
        id_ex_write_en   = we;
    endtask

    task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        drive_base(INSTR_ADD, a, b, 32'd0, 32'd0, rd, 1'b1);
        id_ex_md_en = 1'b1;
        id_ex_md_op = op;
    endtask

    // Issue a mul/div op and wait (bounded) until the stage is ready again.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int n);
        @(negedge clk);
        drive_md(op, a, b, rd);
        tick();
        go_idle();
        n = 0;
        while (ex_id_ready !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        id_ex_md_op = 3'd0;
        drive_base(INSTR_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        go_idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ex_wb_valid, 1'b0);
        check("rst_result", ex_wb_result, 32'd0);
        check("rst_ready", ex_id_ready, 1'b0);
        check("rst_busy", ex_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", ex_id_ready, 1'b1);

        // ADD 5 + 7 -> rd 3
        @(negedge clk);
        drive_base(INSTR_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1);
        #1;
        check("add_mem_addr", mem_addr, 32'd12);
        tick();
        check("add_result", ex_wb_result, 32'd12);
        check("add_rd", ex_wb_rd_addr, 5'd3);
        check("add_valid", ex_wb_valid, 1'b1);
        check("add_we", ex_wb_write_en, 1'b1);

        // Back-to-back base ops
        drive_base(INSTR_SUB, 32'd10, 32'd3, 32'd0, 32'd0, 5'd4, 1'b1);
        tick();
        check("sub_result", ex_wb_result, 32'd7);
        drive_base(INSTR_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5, 1'b1);
        tick();
        check("slt_result", ex_wb_result, 32'd1);
        check("slt_rd", ex_wb_rd_addr, 5'd5);
        go_idle();
        tick();
        check("idle_valid", ex_wb_valid, 1'b0);
        check("idle_we", ex_wb_write_en, 1'b0);
        check("idle_hold", ex_wb_result, 32'd1);

        // BEQ taken to pc+imm = 0x100
        @(negedge clk);
        drive_base(INSTR_BEQ, 32'd9, 32'd9, 32'h10, 32'hF0, 5'd0, 1'b0);
        tick();
        check("beq_take", ex_if_take_branch, 1'b1);
        check("beq_target", ex_if_branch_target, 32'h100);
        check("beq_we", ex_wb_write_en, 1'b0);
        go_idle();
        tick();
        check("beq_take_clr", ex_if_take_branch, 1'b0);

        // Mul/div ops
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, cycles);
        check("mulhu_lat", cycles, 33);
        check("mulhu_result", ex_wb_result, 32'hFFFF_FFFE);
        check("mulhu_valid", ex_wb_valid, 1'b1);
        check("mulhu_rd", ex_wb_rd_addr, 5'd7);
        run_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, cycles);
        check("mul_result", ex_wb_result, 32'h0000_0001);
        run_md(3'd1, 32'hFFFF_FFFD, 32'd5, 5'd8, cycles);
        check("mulh_result", ex_wb_result, 32'hFFFF_FFFF);
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, cycles);
        check("div_ovf", ex_wb_result, 32'h8000_0000);
        check("div_ovf_lat", cycles, 33);
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, cycles);
        check("rem_ovf", ex_wb_result, 32'd0);
        run_md(3'd5, 32'd13, 32'd0, 5'd9, cycles);
        check("divu_zero", ex_wb_result, 32'hFFFF_FFFF);
        check("divu_zero_lat", cycles, 33);
        run_md(3'd7, 32'd13, 32'd0, 5'd9, cycles);
        check("remu_zero", ex_wb_result, 32'd13);
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, cycles);
        check("div_neg", ex_wb_result, 32'hFFFF_FFFD);
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, cycles);
        check("rem_neg", ex_wb_result, 32'hFFFF_FFFF);

        // Flush mid-divide
        @(negedge clk);
        drive_md(3'd4, 32'd100, 32'd7, 5'd10);
        tick();
        go_idle();
        seen = 0;
        repeat (9) begin
            tick();
            if (ex_wb_valid) seen++;
        end
        @(negedge clk);
        flush = 1'b1;
        tick();
        check("flush_busy", ex_busy, 1'b0);
        check("flush_valid", ex_wb_valid, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        drive_base(INSTR_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd11, 1'b1);
        #1;
        check("flush_ready", ex_id_ready, 1'b1);
        tick();
        check("post_flush_add", ex_wb_result, 32'd3);
        check("post_flush_valid", ex_wb_valid, 1'b1);
        go_idle();
        repeat (40) begin
            tick();
            if (ex_wb_valid) seen++;
        end
        check("flush_no_result", seen, 0);

        // DIVU 100/7 with stall held across completion
        @(negedge clk);
        drive_md(3'd5, 32'd100, 32'd7, 5'd12);
        tick();
        go_idle();
        repeat (19) tick();
        stall = 1'b1;
        repeat (20) tick();
        check("stall_busy", ex_busy, 1'b1);
        check("stall_valid", ex_wb_valid, 1'b0);
        @(negedge clk);
        stall = 1'b0;
        tick();
        check("stall_divu", ex_wb_result, 32'd14);
        check("stall_divu_valid", ex_wb_valid, 1'b1);
        check("stall_divu_idle", ex_busy, 1'b0);

        // Async reset mid-BUSY
        @(negedge clk);
        drive_md(3'd0, 32'd3, 32'd4, 5'd13);
        tick();
        go_idle();
        repeat (5) tick();
        check("pre_rst_busy", ex_busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_result", ex_wb_result, 32'd0);
        check("arst_busy", ex_busy, 1'b0);
        check("arst_ready", ex_id_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive_base(INSTR_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 5'd14, 1'b1);
        tick();
        check("post_rst_add", ex_wb_result, 32'd7);
        go_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage with a valid/ready handshake toward decode and an iterative multiply/divide unit (RV32M/RV64M ops) alongside the single-cycle `alu`. Sits between decode and writeback, drives the branch redirect to fetch and the unbuffered data-memory address. Base ALU ops retire in one cycle. Mul/div ops occupy the stage for XLEN+1 cycles and back-pressure decode while busy.

## Interface
- XLEN, 32: datapath width (32 or 64)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  writeback/LSU hold; output registers keep their values
- flush  in  1  squash in-flight and incoming instruction
- id_ex_valid  in  1  decode presents an instruction
- ex_id_ready  out  1  stage accepts an instruction this cycle
- id_ex_instr_type  in  rv32i_instr_e  base-ISA op, forwarded to `alu`
- id_ex_md_en  in  1  instruction is a mul/div op; id_ex_instr_type is ignored
- id_ex_md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc  in  XLEN  operands
- id_ex_rd_addr  in  5  destination register
- id_ex_write_en  in  1  instruction writes rd
- ex_if_take_branch  out  1  registered redirect request
- ex_if_branch_target  out  XLEN  registered redirect target
- ex_wb_valid  out  1  output registers hold a retired instruction
- ex_wb_result  out  XLEN  result
- ex_wb_write_en  out  1  qualified write enable (valid && id_ex_write_en at accept)
- ex_wb_rd_addr  out  5  destination register
- mem_addr  out  XLEN  combinational `alu` result, unbuffered
- ex_busy  out  1  mul/div in progress (state != IDLE)

## Operation
- Accept = id_ex_valid && ex_id_ready. ex_id_ready = (state == IDLE) && !stall && !flush && !rst.
- Base op accepted: output registers load `alu` outputs at the same edge; ex_wb_valid = 1.
- Mul/div accepted: latch op, rd, write_en, operand magnitudes and result signs. State IDLE -> BUSY, counter = 0.
- BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on 2*XLEN-bit internal product/remainder). Counter increments; at counter == XLEN-1, state -> DONE.
- DONE: if !stall, load sign-corrected result into outputs, ex_wb_valid = 1, take_branch = 0, state -> IDLE. If stall, remain in DONE.
- MUL returns low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits with rs1/rs2 signedness per op.
- Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1. Signed overflow (rs1 = min negative, rs2 = -1): DIV -> rs1, REM -> 0. Iteration count is identical in all cases.
- ex_if_take_branch is set only for an accepted base op whose `alu` take_branch is 1; mul/div never branch.
- Cycle with no accept and !stall: ex_wb_valid, ex_wb_write_en, ex_if_take_branch -> 0; other outputs hold.
- Flush (priority over stall and accept): state -> IDLE, ex_wb_valid, ex_wb_write_en, ex_if_take_branch -> 0 at that edge; no instruction is accepted.
- Downstream consumes an output on a cycle with ex_wb_valid && !stall.

## Timing
- Reset (async): all outputs registers 0, state IDLE, counter 0; ex_id_ready = 0 while rst high, 1 on the first cycle after release (no stall/flush).
- Base op latency: 1 edge. Back-to-back base ops: one per cycle.
- Mul/div latency: accept edge k, result visible after edge k+XLEN+1; ex_id_ready low for cycles k+1..k+XLEN+1 (longer if stalled in DONE).
- Stall during BUSY does not pause iteration.
- Reset or flush mid-operation discards partial state; no result is produced.

## Test plan
- ADD rs1=5, rs2=7, write_en=1, rd=3 -> next edge result 12, rd 3, valid 1, write_en 1; mem_addr 12 combinationally before the edge.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF (XLEN=32) -> ex_id_ready low 33 cycles, result 0xFFFFFFFE on edge k+33; MUL same operands -> 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 13/0 -> 0xFFFFFFFF; REMU 13/0 -> 13; DIV -7/2 -> -3, REM -> -1.
- BEQ taken, target pc+imm = 0x100 -> take_branch 1, target 0x100 for one cycle; following idle cycle -> take_branch 0.
- DIV accepted, flush at cycle 10 -> no valid pulse, ex_busy 0 next cycle, ADD accepted the cycle after flush deasserts.
- DIVU 100/7 with stall held from cycle 20 to 40 -> state held in DONE, result 14 loads on first edge with stall low; async rst mid-BUSY -> all outputs 0 immediately.
